// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider: operands and START in,
// BUSY/VALID handshake plus quotient, remainder and divide-error out.
interface seq_divider_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic                 busy;
    logic                 valid;
    logic [OUT_WIDTH-1:0] q;
    logic [OUT_WIDTH-1:0] r;
    logic                 de;

    modport master (
        output start, in1, in2,
        input  busy, valid, q, r, de
    );

    modport slave (
        input  start, in1, in2,
        output busy, valid, q, r, de
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// quotient and remainder delivered together with a one-cycle VALID pulse.
module seq_divider #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;

    // The dividend register doubles as the quotient register: each iteration
    // shifts one dividend bit out of the top and one quotient bit in at the bottom.
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_de;

    logic             w_accept;
    logic             w_dz;
    logic             w_last;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_nx;

    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_dz     = (bus.in2 == '0);
    assign w_last   = (r_cnt == LAST_CNT);

    // When rem' >= divisor the true difference is below the divisor, so a
    // WIDTH-bit subtraction is exact and the carry bit only matters for the compare.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nx = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = w_dz ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_state_nx = w_dz ? S_DONE : S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_de  <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= bus.in1;
            r_dvs <= bus.in2;
            r_rem <= '0;
            r_cnt <= '0;
            r_de  <= 1'b0;
            // Divide by zero completes on the accepting edge itself.
            if (w_dz) begin
                r_q  <= '0;
                r_r  <= '0;
                r_de <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_q <= {r_dvd[WIDTH-2:0], w_ge};
                r_r <= w_rem_nx;
            end
        end
    end

    assign bus.busy  = (r_state == S_RUN);
    assign bus.valid = (r_state == S_DONE);
    assign bus.q     = OUT_WIDTH'(r_q);
    assign bus.r     = OUT_WIDTH'(r_r);
    assign bus.de    = r_de;
endmodule
